// File: rtl/axi_rd_arbiter_pkg.sv
// cpu_defs: shared types and constants for the AXI read-channel arbiter.
package cpu_defs;

    typedef logic [31:0]  uint32_t;
    typedef logic [127:0] uint128_t;

    typedef enum logic [1:0] {IDLE, AR, R} arb_state_t;
    typedef enum logic {OWN_ICACHE, OWN_DATA} arb_owner_t;

    localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
    localparam int         ICACHE_LINE_BEATS = 4;

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if: AXI3 read address / read data channel bundle.
interface axi_rd_arbiter_if;
    import cpu_defs::*;

    logic [3:0] arid;
    uint32_t    araddr;
    logic [7:0] arlen;
    logic [2:0] arsize;
    logic [1:0] arburst;
    logic [1:0] arlock;
    logic [3:0] arcache;
    logic [2:0] arprot;
    logic       arvalid;
    logic       arready;
    logic [3:0] rid;
    uint32_t    rdata;
    logic [1:0] rresp;
    logic       rlast;
    logic       rvalid;
    logic       rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );

endinterface

// File: rtl/axi_rd_arbiter_line_buf.sv
// axi_rd_line_buf: beat counter and 128-bit line assembly; line_nxt includes the beat being written.
module axi_rd_line_buf
    import cpu_defs::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     clr,
    input  logic     wr,
    input  uint32_t  wdata,
    output uint128_t line_nxt
);

    logic [1:0] cnt;
    uint128_t   line;

    // Merge the incoming beat into its slot so the final line is visible on the last beat.
    always_comb begin
        line_nxt = line;
        if (wr) line_nxt[{cnt, 5'b0} +: 32] = wdata;
    end

    // Clear at the start of each data phase, then append one slot per accepted beat.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt  <= '0;
            line <= '0;
        end else if (wr) begin
            cnt  <= cnt + 2'd1;
            line <= line_nxt;
        end
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: icache/data read scheduler onto one AXI3 AR/R pair; AXI_RD_ARB_PERF_EN adds perf counters.
module axi_rd_arbiter
    import cpu_defs::*;
#(
    parameter bit         DATA_FIRST = 1'b1,
    parameter logic [3:0] ICACHE_ID  = 4'd0,
    parameter logic [3:0] DATA_ID    = 4'd1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       icache_req,
    input  logic       icache_uncache,
    input  uint32_t    icache_addr,
    output logic       icache_addr_ready,
    output logic       icache_data_ready,
    output uint128_t   icache_rdata,
    input  logic       data_req,
    input  logic [1:0] data_size,
    input  uint32_t    data_addr,
    output logic       data_addr_ok,
    output logic       data_data_ok,
    output uint32_t    data_rdata,
`ifdef AXI_RD_ARB_PERF_EN
    output uint32_t    perf_icache_cnt,
    output uint32_t    perf_data_cnt,
    output uint32_t    perf_stall_cnt,
`endif
    axi_rd_arbiter_if.master axi
);

    arb_state_t state_q, state_d;
    arb_owner_t owner_q;
    logic       done_q;
    logic       grant_data, grant_icache, hit, fin, ar_fire;
    uint128_t   line_nxt;

    assign grant_data   = state_q == IDLE && data_req && (DATA_FIRST || !icache_req);
    assign grant_icache = state_q == IDLE && icache_req && !grant_data;
    assign ar_fire      = state_q == AR && axi.arready;
    assign hit          = state_q == R && axi.rvalid && axi.rid == axi.arid;
    assign fin          = hit && axi.rlast;

    assign axi.arburst = AXI_BURST_INCR;
    assign axi.arlock  = '0;
    assign axi.arcache = '0;
    assign axi.arprot  = '0;

    // Next state plus handshake/pulse outputs; acceptance is combinational in IDLE.
    always_comb begin
        state_d = state_q == IDLE ? ((grant_data || grant_icache) ? AR : IDLE)
                : state_q == AR   ? (axi.arready ? R : AR)
                :                   (fin ? IDLE : R);
        axi.arvalid       = state_q == AR;
        axi.rready        = state_q == R;
        icache_addr_ready = grant_icache;
        data_addr_ok      = grant_data;
        icache_data_ready = done_q && owner_q == OWN_ICACHE;
        data_data_ok      = done_q && owner_q == OWN_DATA;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Latch the winner's request; AR fields stay frozen until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q    <= OWN_ICACHE;
            axi.arid   <= '0;
            axi.araddr <= '0;
            axi.arlen  <= '0;
            axi.arsize <= '0;
        end else if (grant_data || grant_icache) begin
            owner_q    <= grant_data ? OWN_DATA : OWN_ICACHE;
            axi.arid   <= grant_data ? DATA_ID : ICACHE_ID;
            axi.araddr <= grant_data ? data_addr : icache_uncache ? icache_addr : {icache_addr[31:4], 4'b0};
            axi.arlen  <= (grant_data || icache_uncache) ? 8'd0 : 8'(ICACHE_LINE_BEATS - 1);
            axi.arsize <= grant_data ? {1'b0, data_size} : 3'd2;
        end
    end

    // Capture the finished line/word into the owner's hold register and arm the return pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            done_q       <= 1'b0;
            icache_rdata <= '0;
            data_rdata   <= '0;
        end else begin
            done_q <= fin;
            if (fin && owner_q == OWN_DATA)   data_rdata   <= line_nxt[31:0];
            if (fin && owner_q == OWN_ICACHE) icache_rdata <= line_nxt;
        end
    end

    axi_rd_line_buf u_line_buf (
        .clk      (clk),
        .reset    (reset),
        .clr      (ar_fire),
        .wr       (hit),
        .wdata    (axi.rdata),
        .line_nxt (line_nxt)
    );

`ifdef AXI_RD_ARB_PERF_EN
    // Saturating completion and stall counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_icache_cnt <= '0;
            perf_data_cnt   <= '0;
            perf_stall_cnt  <= '0;
        end else begin
            perf_icache_cnt <= perf_icache_cnt + 32'(icache_data_ready && perf_icache_cnt != '1);
            perf_data_cnt   <= perf_data_cnt + 32'(data_data_ok && perf_data_cnt != '1);
            perf_stall_cnt  <= perf_stall_cnt + 32'(((icache_req && !icache_addr_ready) ||
                                                     (data_req && !data_addr_ok)) && perf_stall_cnt != '1);
        end
    end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed self-checking bench for axi_rd_arbiter.
module tb_axi_rd_arbiter;
    import cpu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_req, icache_uncache, icache_addr_ready, icache_data_ready;
    logic [31:0] icache_addr;
    logic [127:0] icache_rdata;
    logic        data_req, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_rdata;
`ifdef AXI_RD_ARB_PERF_EN
    logic [31:0] perf_icache_cnt, perf_data_cnt, perf_stall_cnt;
`endif
    int checks = 0;
    int errors = 0;

    axi_rd_arbiter_if bus();

    axi_rd_arbiter dut (
        .clk               (clk),
        .reset             (reset),
        .icache_req        (icache_req),
        .icache_uncache    (icache_uncache),
        .icache_addr       (icache_addr),
        .icache_addr_ready (icache_addr_ready),
        .icache_data_ready (icache_data_ready),
        .icache_rdata      (icache_rdata),
        .data_req          (data_req),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_addr_ok      (data_addr_ok),
        .data_data_ok      (data_data_ok),
        .data_rdata        (data_rdata),
`ifdef AXI_RD_ARB_PERF_EN
        .perf_icache_cnt   (perf_icache_cnt),
        .perf_data_cnt     (perf_data_cnt),
        .perf_stall_cnt    (perf_stall_cnt),
`endif
        .axi               (bus)
    );

    always #5 clk = ~clk;

    task step;
        @(posedge clk);
        #1;
    endtask

    task beat(input logic [3:0] id, input logic [31:0] d, input logic last);
        bus.rvalid = 1'b1;
        bus.rid    = id;
        bus.rdata  = d;
        bus.rlast  = last;
        step;
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
        bus.rid    = '0;
        bus.rdata  = '0;
    endtask

    task test_reset;
        reset = 1'b1;
        repeat (3) step;
        reset = 1'b0;
        #1;
        checks++; if (bus.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid: got %b want 0", bus.arvalid); end
        checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL reset_rready: got %b want 0", bus.rready); end
        checks++; if (icache_data_ready !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL reset_pulses: got %b%b want 00", icache_data_ready, data_data_ok); end
        checks++; if (icache_rdata !== 128'h0 || data_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h %h want 0", icache_rdata, data_rdata); end
    endtask

    task test_icache_cached;
        icache_req = 1'b1; icache_uncache = 1'b0; icache_addr = 32'h1FC0_0024;
        #1;
        checks++; if (icache_addr_ready !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL ic_accept: got %b%b want 10", icache_addr_ready, data_addr_ok); end
        step;
        icache_req = 1'b0; icache_addr = 32'h0;
        #1;
        checks++; if (bus.arvalid !== 1'b1) begin errors++; $display("FAIL ic_arvalid: got %b want 1", bus.arvalid); end
        checks++; if (bus.araddr !== 32'h1FC0_0020) begin errors++; $display("FAIL ic_araddr: got %h want 1fc00020", bus.araddr); end
        checks++; if (bus.arlen !== 8'd3 || bus.arsize !== 3'd2 || bus.arid !== 4'd0) begin errors++; $display("FAIL ic_arfields: got len %0d size %0d id %0d want 3 2 0", bus.arlen, bus.arsize, bus.arid); end
        checks++; if (bus.arburst !== 2'b01) begin errors++; $display("FAIL ic_arburst: got %b want 01", bus.arburst); end
        step;
        checks++; if (bus.rready !== 1'b1) begin errors++; $display("FAIL ic_rready: got %b want 1", bus.rready); end
        beat(4'd0, 32'h11, 1'b0);
        beat(4'd0, 32'h22, 1'b0);
        beat(4'd0, 32'h33, 1'b0);
        checks++; if (icache_data_ready !== 1'b0) begin errors++; $display("FAIL ic_early_ready: got %b want 0", icache_data_ready); end
        beat(4'd0, 32'h44, 1'b1);
        checks++; if (icache_data_ready !== 1'b1) begin errors++; $display("FAIL ic_ready: got %b want 1", icache_data_ready); end
        checks++; if (icache_rdata !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL ic_line: got %h want 00000044000000330000002200000011", icache_rdata); end
        checks++; if (bus.rready !== 1'b0) begin errors++; $display("FAIL ic_idle_rready: got %b want 0", bus.rready); end
        step;
        checks++; if (icache_data_ready !== 1'b0) begin errors++; $display("FAIL ic_single_pulse: got %b want 0", icache_data_ready); end
        checks++; if (icache_rdata !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL ic_line_hold: got %h", icache_rdata); end
    endtask

    task test_data_read;
        data_req = 1'b1; data_size = 2'd1; data_addr = 32'h8000_0002;
        #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL d_accept: got %b want 1", data_addr_ok); end
        step;
        data_req = 1'b0; data_addr = 32'h0; data_size = 2'd0;
        #1;
        checks++; if (bus.arsize !== 3'd1 || bus.arlen !== 8'd0 || bus.arid !== 4'd1) begin errors++; $display("FAIL d_arfields: got size %0d len %0d id %0d want 1 0 1", bus.arsize, bus.arlen, bus.arid); end
        checks++; if (bus.araddr !== 32'h8000_0002) begin errors++; $display("FAIL d_araddr: got %h want 80000002", bus.araddr); end
        step;
        beat(4'd1, 32'hABCD_1234, 1'b1);
        checks++; if (data_data_ok !== 1'b1 || icache_data_ready !== 1'b0) begin errors++; $display("FAIL d_ok: got %b%b want 10", data_data_ok, icache_data_ready); end
        checks++; if (data_rdata !== 32'hABCD_1234) begin errors++; $display("FAIL d_rdata: got %h want abcd1234", data_rdata); end
        checks++; if (icache_rdata !== 128'h00000044_00000033_00000022_00000011) begin errors++; $display("FAIL d_ic_hold: got %h", icache_rdata); end
        step;
        checks++; if (data_data_ok !== 1'b0) begin errors++; $display("FAIL d_single_pulse: got %b want 0", data_data_ok); end
    endtask

    task test_both_requests;
        icache_req = 1'b1; icache_uncache = 1'b0; icache_addr = 32'h0000_2000;
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h0000_3000;
        #1;
        checks++; if (data_addr_ok !== 1'b1 || icache_addr_ready !== 1'b0) begin errors++; $display("FAIL both_first: got d%b i%b want d1 i0", data_addr_ok, icache_addr_ready); end
        step;
        data_req = 1'b0;
        #1;
        checks++; if (icache_addr_ready !== 1'b0 || bus.arid !== 4'd1) begin errors++; $display("FAIL both_hold: got ready %b id %0d want 0 1", icache_addr_ready, bus.arid); end
        step;
        beat(4'd1, 32'h77, 1'b1);
        checks++; if (data_data_ok !== 1'b1 || icache_addr_ready !== 1'b1 || data_addr_ok !== 1'b0) begin errors++; $display("FAIL both_return: got ok %b ready %b aok %b want 1 1 0", data_data_ok, icache_addr_ready, data_addr_ok); end
        checks++; if (data_rdata !== 32'h77) begin errors++; $display("FAIL both_drdata: got %h want 77", data_rdata); end
        step;
        icache_req = 1'b0;
        #1;
        checks++; if (bus.arid !== 4'd0 || bus.araddr !== 32'h0000_2000 || bus.arlen !== 8'd3) begin errors++; $display("FAIL both_ic_ar: got id %0d addr %h len %0d", bus.arid, bus.araddr, bus.arlen); end
        step;
        beat(4'd0, 32'hA, 1'b0);
        beat(4'd0, 32'hB, 1'b0);
        beat(4'd0, 32'hC, 1'b0);
        beat(4'd0, 32'hD, 1'b1);
        checks++; if (icache_data_ready !== 1'b1 || icache_rdata !== 128'h0000000D_0000000C_0000000B_0000000A) begin errors++; $display("FAIL both_ic_line: got %b %h", icache_data_ready, icache_rdata); end
        step;
    endtask

    task test_uncached;
        icache_req = 1'b1; icache_uncache = 1'b1; icache_addr = 32'hBFC0_0008;
        #1;
        checks++; if (icache_addr_ready !== 1'b1) begin errors++; $display("FAIL unc_accept: got %b want 1", icache_addr_ready); end
        step;
        icache_req = 1'b0; icache_uncache = 1'b0;
        #1;
        checks++; if (bus.araddr !== 32'hBFC0_0008 || bus.arlen !== 8'd0 || bus.arsize !== 3'd2) begin errors++; $display("FAIL unc_ar: got addr %h len %0d size %0d", bus.araddr, bus.arlen, bus.arsize); end
        step;
        beat(4'd0, 32'hCAFE_F00D, 1'b1);
        checks++; if (icache_data_ready !== 1'b1 || icache_rdata !== {96'h0, 32'hCAFE_F00D}) begin errors++; $display("FAIL unc_line: got %b %h", icache_data_ready, icache_rdata); end
        step;
    endtask

    task test_rid_mismatch;
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h0000_0100;
        step;
        data_req = 1'b0;
        step;
        beat(4'd0, 32'h0000_0BAD, 1'b1);
        checks++; if (data_data_ok !== 1'b0 || bus.rready !== 1'b1) begin errors++; $display("FAIL rid_drop: got ok %b rready %b want 0 1", data_data_ok, bus.rready); end
        beat(4'd1, 32'h0000_600D, 1'b1);
        checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h0000_600D) begin errors++; $display("FAIL rid_match: got %b %h want 1 0000600d", data_data_ok, data_rdata); end
        step;
    endtask

    task test_ar_stall;
        bus.arready = 1'b0;
        data_req = 1'b1; data_size = 2'd2; data_addr = 32'h1234_5678;
        step;
        data_req = 1'b0; data_addr = 32'h0;
        for (int i = 0; i < 5; i++) begin
            bus.rvalid = 1'b1; bus.rid = 4'd1; bus.rdata = 32'hDEAD_BEEF; bus.rlast = 1'b1;
            #1;
            checks++; if (bus.arvalid !== 1'b1 || bus.araddr !== 32'h1234_5678 || bus.arlen !== 8'd0 || bus.arid !== 4'd1 || bus.rready !== 1'b0) begin
                errors++; $display("FAIL stall_%0d: got v%b addr %h len %0d id %0d rready %b", i, bus.arvalid, bus.araddr, bus.arlen, bus.arid, bus.rready);
            end
            step;
        end
        bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = '0;
        bus.arready = 1'b1;
        step;
        beat(4'd1, 32'h5555_5555, 1'b1);
        checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h5555_5555) begin errors++; $display("FAIL stall_data: got %b %h want 1 55555555", data_data_ok, data_rdata); end
        step;
    endtask

    task test_reset_mid_burst;
        icache_req = 1'b1; icache_uncache = 1'b0; icache_addr = 32'h0000_0040;
        step;
        icache_req = 1'b0;
        step;
        beat(4'd0, 32'h1, 1'b0);
        beat(4'd0, 32'h2, 1'b0);
        bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'h3; reset = 1'b1;
        step;
        reset = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
        #1;
        checks++; if (bus.arvalid !== 1'b0 || bus.rready !== 1'b0 || icache_data_ready !== 1'b0 || data_data_ok !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got %b%b%b%b want 0000", bus.arvalid, bus.rready, icache_data_ready, data_data_ok); end
        checks++; if (icache_rdata !== 128'h0 || data_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_data: got %h %h want 0", icache_rdata, data_rdata); end
        checks++; if (bus.araddr !== 32'h0 || bus.arlen !== 8'd0 || bus.arid !== 4'd0 || bus.arsize !== 3'd0) begin errors++; $display("FAIL rst_mid_ar: got %h %0d %0d %0d want 0", bus.araddr, bus.arlen, bus.arid, bus.arsize); end
        step;
        checks++; if (icache_data_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_noready: got %b want 0", icache_data_ready); end
        data_req = 1'b1; data_size = 2'd0; data_addr = 32'h0000_0203;
        #1;
        checks++; if (data_addr_ok !== 1'b1) begin errors++; $display("FAIL rst_mid_accept: got %b want 1", data_addr_ok); end
        step;
        data_req = 1'b0;
        #1;
        checks++; if (bus.arsize !== 3'd0 || bus.araddr !== 32'h0000_0203) begin errors++; $display("FAIL rst_mid_ar2: got size %0d addr %h", bus.arsize, bus.araddr); end
        step;
        beat(4'd1, 32'h99, 1'b1);
        checks++; if (data_data_ok !== 1'b1 || data_rdata !== 32'h99) begin errors++; $display("FAIL rst_mid_done: got %b %h want 1 99", data_data_ok, data_rdata); end
        step;
    endtask

    initial begin
        icache_req = 1'b0; icache_uncache = 1'b0; icache_addr = '0;
        data_req = 1'b0; data_size = '0; data_addr = '0;
        bus.arready = 1'b1; bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
        test_reset;
        test_icache_cached;
        test_data_read;
        test_both_requests;
        test_uncached;
        test_rid_mismatch;
        test_ar_stall;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Read-channel scheduler between the instruction-cache refill port and the data sram-like read port, driving a single AXI3 AR/R channel pair.
- Sits between icache/cpu_core and the AXI bus. Write traffic (AW/W/B) bypasses this block.
- One outstanding AXI read at a time.
- Cached icache refills are 4-beat INCR bursts assembled into a 128-bit line. Data and uncached reads are single beats.

Parameters:
- DATA_FIRST, 1: fixed priority. 1 = the data port wins a simultaneous request; 0 = the icache port wins.
- ICACHE_ID, 4'd0: arid used for icache transactions.
- DATA_ID, 4'd1: arid used for data transactions.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- icache_req  in  1  icache read request.
- icache_uncache  in  1  1 = single-word uncached read.
- icache_addr  in  32  icache read address.
- icache_addr_ready  out  1  request accepted (1-cycle pulse).
- icache_data_ready  out  1  line/word return (1-cycle pulse).
- icache_rdata  out  128  returned line; uncached word in [31:0], rest zero.
- data_req  in  1  data read request; writes are not routed here.
- data_size  in  2  0 = byte, 1 = half, 2 = word.
- data_addr  in  32  data read address.
- data_addr_ok  out  1  request accepted (pulse).
- data_data_ok  out  1  read data valid (pulse).
- data_rdata  out  32  read data.
- arid  out  4  AXI AR id.
- araddr  out  32  AXI AR address.
- arlen  out  8  AXI AR burst length.
- arsize  out  3  AXI AR beat size.
- arburst  out  2  AXI AR burst type.
- arlock  out  2  AXI AR lock.
- arcache  out  4  AXI AR cache.
- arprot  out  3  AXI AR prot.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rid  in  4  AXI R id.
- rdata  in  32  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last beat.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Behaviour:
- State machine: IDLE -> AR -> R -> IDLE.
- Reset: state = IDLE. Every output pulse, arvalid, rready, beat counter, owner and data registers = 0.
- IDLE, arbitration:
  - If any request is present, grant one port per DATA_FIRST and pulse that port's addr_ok/addr_ready for 1 cycle, combinationally in the same cycle as the request.
  - Latch the request into registers: owner, addr, len, size. Next state = AR.
  - The losing port sees no acceptance pulse and must hold its request.
- Latched AR fields:
  - Icache cached: araddr = {addr[31:4], 4'b0}, arlen = 3, arsize = 2.
  - Icache uncached: araddr = addr, arlen = 0, arsize = 2.
  - Data: araddr = addr, arlen = 0, arsize = {1'b0, data_size}.
  - Always: arburst = 2'b01, arlock = 0, arcache = 0, arprot = 0, arid = owner's ID.
- AR: arvalid = 1 and AR fields stay stable until arready. The cycle arvalid & arready is seen, next state = R with beat counter = 0.
- R:
  - rready = 1.
  - On each beat with rvalid & rid == owner's ID, write rdata into beat slot [cnt*32 +: 32] and increment cnt (2-bit, wraps).
  - Beats with a mismatched rid are accepted and dropped.
- Completion: the beat with rlast & rvalid & matching rid ends the transaction.
  - Next cycle, pulse the owner's data_ready/data_ok for exactly 1 cycle with registered data. Uncached and data reads deliver beat 0.
  - Return to IDLE in that same cycle.
  - Minimum request-to-data latency = 4 cycles (accept, AR, R beat, return).
- New arbitration can occur in the return cycle, so back-to-back requests are accepted with zero bubble after completion.
- rresp is ignored in the base build.
- Request changes after acceptance do not affect the latched transaction.
- Simultaneous requests on both ports: exactly one acceptance pulse per cycle.
- Reset asserted mid-AR or mid-R: abandon immediately, clear all outputs. The AXI slave is reset by the same signal.
- icache_rdata and data_rdata hold their last values outside return pulses.

Optional Feature:
- AXI_RD_ARB_PERF_EN defined adds outputs perf_icache_cnt[31:0], perf_data_cnt[31:0] and perf_stall_cnt[31:0]:
  - perf_icache_cnt / perf_data_cnt count completed transactions per port.
  - perf_stall_cnt counts cycles where a request is present and not accepted.
  - All three are saturating, reset to 0.
- Undefined: these ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_defs:
  - typedef enum logic [1:0] arb_state_t {IDLE, AR, R}.
  - typedef enum logic arb_owner_t {OWN_ICACHE, OWN_DATA}.
  - Constants AXI_BURST_INCR = 2'b01 and ICACHE_LINE_BEATS = 4.
  - Reuse of uint32_t / uint128_t.
- One sub-module: axi_rd_line_buf, the beat counter plus 128-bit assembly register (clear, write beat, read line).

Test Plan:
- Icache cached req addr 0x1FC0_0024, arready on cycle 1, beats 0x11, 0x22, 0x33, 0x44 -> araddr 0x1FC0_0020, arlen 3, arid 0, icache_rdata 0x00000044_00000033_00000022_00000011, single data_ready pulse.
- Data req size 1 addr 0x8000_0002, rdata 0xABCD_1234 -> arsize 1, arlen 0, arid 1, data_rdata 0xABCD_1234, one data_ok pulse 4 cycles after req with zero wait states.
- Both req same cycle, DATA_FIRST = 1 -> data_addr_ok first; icache_addr_ready in the data-return cycle; icache burst follows; never two acceptance pulses in one cycle.
- arready held low 5 cycles -> araddr, arlen and arid unchanged throughout; no R accepted before the AR handshake.
- Reset asserted during beat 2 of an icache burst -> next cycle all outputs 0, state IDLE, no data_ready; a fresh data req afterwards completes normally.
- Icache uncached addr 0xBFC0_0008 -> araddr exact, arlen 0, icache_rdata[127:32] = 0.
